nes_pad_reader: RTL and testbench
=================================

// Module: nes_pad_reader
// PURPOSE
//  Reads one NES controller (4021 shift register) per request. Drives the pad's
//  latch and clock lines, shifts in 8 serial button bits and presents them as a
//  parallel, active-high button byte with a one-cycle valid strobe.
//  Sits between the pad pins and game/LED logic. Owns its own latch and clock
//  timing, so there is no separate free-running clock generator.
// PARAMETERS
//  HALF_PERIOD  6  clk cycles per half pad-clock period; latch width = 2*HALF_PERIOD; must be >= 4
// PORTS
//  clk         in   1  system clock; all state updates on posedge
//  reset       in   1  asynchronous, active-low reset (0 = reset asserted)
//  start       in   1  request one read; sampled only in IDLE
//  nes_data    in   1  serial data from pad; active-low (0 = button pressed); asynchronous
//  nes_latch   out  1  pad latch (parallel load), active-high
//  nes_clk     out  1  pad shift clock; idles low
//  buttons     out  8  last completed read, 1 = pressed; [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//  valid       out  1  1-cycle strobe: buttons updated this cycle
//  busy        out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (reset==0, any time incl. mid-read):
//   - state=IDLE; nes_latch, nes_clk, valid, busy = 0; buttons = 8'h00.
//   - Counters and shift register are cleared.
//   - No valid is produced for an interrupted read.
//  All outputs are registered. H = HALF_PERIOD.
//  nes_data passes through a 2-flop synchronizer before use (2-cycle lag, covered by H>=4).
//  FSM states: IDLE, LATCH, SHIFT, DONE.
//   IDLE : if start==1 at edge E0, go to LATCH.
//   LATCH: nes_latch=1 for exactly 2H cycles, starting the cycle after E0. Then go to SHIFT, slot k=0.
//   SHIFT: 8 slots k=0..7, each 2H cycles, phase counter p=0..2H-1.
//     - p<H: nes_clk=0.
//     - p>=H: nes_clk=1 for k<7; nes_clk=0 for k=7 (7 rising edges total).
//     - At p==H-1: shift_reg[k] <= ~nes_data_sync (LSB first, inverts active-low data).
//     - At end of slot 7, go to DONE.
//   DONE : one cycle; buttons <= shift_reg, valid=1; then back to IDLE.
//  Latency: valid is high exactly 18H+1 cycles after E0 (H=6 gives 109).
//   busy is high from E0+1 through the valid cycle inclusive.
//  start handling:
//   - start while busy is ignored; it is not queued.
//   - start held high gives back-to-back reads, with exactly one IDLE cycle between valid and the next latch.
//  buttons holds its value between reads; it changes only in DONE or on reset.
//  Phase counter is sized $clog2(2*H) bits; it wraps to 0 at 2H-1 and never exceeds 2H-1.
// STRUCTURE
//  nes_pkg (shared package):
//   - typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} nes_state_t.
//   - Button index localparams BTN_A=0 ... BTN_RIGHT=7.
//   - NES_BITS=8.
//  One sub-module: nes_phase_counter.
//   - Parameter H; inputs clk, reset, clear; outputs p, half_tick (p==H-1), end_tick (p==2H-1).
//  The FSM, synchronizer and shift register stay in nes_pad_reader.
// TESTING
//  1 Reset: hold reset=0 with random inputs -> all outputs 0, buttons 8'h00. Release -> IDLE, busy=0.
//  2 Single read, H=6: pad model presents buttons 8'hA5 (line low for pressed bits), shifting on nes_clk rise.
//    -> nes_latch high exactly 12 cycles; 7 nes_clk pulses each 6 high / 6 low;
//       valid at E0+109 for 1 cycle; buttons==8'hA5; busy low the cycle after.
//  3 Idle pad (nes_data=1 constantly) -> buttons==8'h00; all low (nes_data=0) -> buttons==8'hFF.
//  4 start pulsed again at E0+30 -> ignored: exactly one valid, no second latch.
//    start held high -> next nes_latch rises 2 cycles after valid.
//  5 reset asserted at E0+50 (mid-SHIFT) -> outputs 0 immediately.
//    No valid; buttons stays 8'h00 after release until a fresh start completes.
//  6 H=4 build, pattern 8'h3C -> valid at E0+73, buttons==8'h3C, latch width 8 cycles.

Source files
------------

// File: rtl/nes_pad_reader_pkg.sv
// rtl/nes_pad_reader_pkg.sv - shared types and constants for the NES pad reader
// Purpose: FSM state encoding, button bit positions and the button count.
// Ports  : none (package).
package nes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } nes_state_t;

  localparam int NES_BITS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_pad_reader_if.sv
// rtl/nes_pad_reader_if.sv - request/result and pad-pin bundle for the NES pad reader
// Purpose: groups the host request/result signals and the pad pins.
// Ports  : start, nes_data (into the reader); nes_latch, nes_clk, buttons,
//          valid, busy (out of the reader). slave = reader, master = host/pad side.
interface nes_pad_reader_if;
  import nes_pkg::*;

  logic                start;
  logic                nes_data;
  logic                nes_latch;
  logic                nes_clk;
  logic [NES_BITS-1:0] buttons;
  logic                valid;
  logic                busy;

  modport slave (
    input  start,
    input  nes_data,
    output nes_latch,
    output nes_clk,
    output buttons,
    output valid,
    output busy
  );

  modport master (
    output start,
    output nes_data,
    input  nes_latch,
    input  nes_clk,
    input  buttons,
    input  valid,
    input  busy
  );

endinterface

// File: rtl/nes_pad_reader_phase_counter.sv
// rtl/nes_pad_reader_phase_counter.sv - phase counter for pad latch/clock timing
// Purpose: counts p = 0..2H-1 and wraps; flags the mid-period and end-of-period cycles.
// Ports  : clk, reset (async, active-low), clear (hold p at 0),
//          p (phase), half_tick (p == H-1), end_tick (p == 2H-1).
module nes_phase_counter #(
  parameter  int H  = 6,
  localparam int PW = $clog2(2 * H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic [PW-1:0] p,
  output logic          half_tick,
  output logic          end_tick
);

  assign half_tick = (p == PW'(H - 1));
  assign end_tick  = (p == PW'(2 * H - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p <= '0;
    end else if (clear || end_tick) begin
      p <= '0;
    end else begin
      p <= p + 1'b1;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// rtl/nes_pad_reader.sv - reads one NES controller (4021) per start request
// Purpose: drives latch and shift clock, shifts in 8 active-low bits LSB first,
//          presents them active-high on buttons with a one-cycle valid strobe.
// Ports  : clk, reset (async, active-low), pad (nes_pad_reader_if.slave):
//          start in, nes_data in (async), nes_latch/nes_clk/buttons/valid/busy out.
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int HALF_PERIOD = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  nes_pad_reader_if.slave       pad
);

  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam int KW = $clog2(NES_BITS);

  nes_state_t          state, state_nxt;
  logic [PW-1:0]       p;
  logic                half_tick, end_tick;
  logic [KW-1:0]       k;
  logic [NES_BITS-1:0] shift_reg;
  logic                sync1, sync2;
  logic                latch_d, clk_d, valid_d, busy_d;
  logic                last_slot;

  assign last_slot = (k == KW'(NES_BITS - 1));

  nes_phase_counter #(.H(HALF_PERIOD)) u_phase (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == IDLE || state == DONE),
    .p         (p),
    .half_tick (half_tick),
    .end_tick  (end_tick)
  );

  // Two-flop synchronizer for the asynchronous pad data line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pad.nes_data;
      sync2 <= sync1;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (pad.start)             state_nxt = LATCH;
      LATCH: if (end_tick)              state_nxt = SHIFT;
      SHIFT: if (end_tick && last_slot) state_nxt = DONE;
      DONE:                             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // FSM: outputs, registered below so every pad pin is glitch-free.
  // The last slot has no rising edge: the 4021 already presents bit 7 after 7 shifts.
  always_comb begin
    latch_d = (state == LATCH);
    clk_d   = (state == SHIFT) && (p >= PW'(HALF_PERIOD)) && !last_slot;
    valid_d = (state == DONE);
    busy_d  = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pad.nes_latch <= 1'b0;
      pad.nes_clk   <= 1'b0;
      pad.valid     <= 1'b0;
      pad.busy      <= 1'b0;
    end else begin
      pad.nes_latch <= latch_d;
      pad.nes_clk   <= clk_d;
      pad.valid     <= valid_d;
      pad.busy      <= busy_d;
    end
  end

  // Slot index: advances once per full pad-clock period while shifting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k <= '0;
    end else if (state != SHIFT) begin
      k <= '0;
    end else if (end_tick) begin
      k <= k + 1'b1;
    end
  end

  // Sample at the end of the low half, well after the previous rising edge
  // has settled through the synchronizer; invert the active-low line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
    end else if (state == SHIFT && half_tick) begin
      shift_reg[k] <= ~sync2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pad.buttons <= '0;
    end else if (state == DONE) begin
      pad.buttons <= shift_reg;
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb/tb_nes_pad_reader.sv - self-checking bench for nes_pad_reader (H=6 and H=4 builds)
module tb_nes_pad_reader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_drv = 1'b0;
  logic sel = 1'b0;
  logic [7:0] pad_line = 8'hFF;
  int   idx_a = 8;
  int   idx_b = 8;
  int   n_pass = 0;
  int   n_total = 0;
  logic [7:0] last_btn [2];

  always #5 clk = ~clk;

  nes_pad_reader_if ifa ();
  nes_pad_reader_if ifb ();

  nes_pad_reader #(.HALF_PERIOD(6)) dut_a (.clk(clk), .reset(reset), .pad(ifa));
  nes_pad_reader #(.HALF_PERIOD(4)) dut_b (.clk(clk), .reset(reset), .pad(ifb));

  assign ifa.start = start_drv & ~sel;
  assign ifb.start = start_drv & sel;

  // Pad model: parallel load on latch, next bit on each shift-clock rise,
  // line driven low for a pressed button.
  always @(posedge ifa.nes_latch or posedge ifa.nes_clk)
    if (ifa.nes_latch) idx_a = 0; else idx_a = idx_a + 1;
  always @(posedge ifb.nes_latch or posedge ifb.nes_clk)
    if (ifb.nes_latch) idx_b = 0; else idx_b = idx_b + 1;

  assign ifa.nes_data = (idx_a < 8) ? pad_line[idx_a[2:0]] : 1'b1;
  assign ifb.nes_data = (idx_b < 8) ? pad_line[idx_b[2:0]] : 1'b1;

  logic       c_latch, c_clk, c_valid, c_busy;
  logic [7:0] c_buttons;
  assign c_latch   = sel ? ifb.nes_latch : ifa.nes_latch;
  assign c_clk     = sel ? ifb.nes_clk   : ifa.nes_clk;
  assign c_valid   = sel ? ifb.valid     : ifa.valid;
  assign c_busy    = sel ? ifb.busy      : ifa.busy;
  assign c_buttons = sel ? ifb.buttons   : ifa.buttons;

  typedef struct {
    logic [7:0] line;
    logic [7:0] exp;
  } vec_t;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endfunction

  // One read on the selected instance; timing expectations come from H alone.
  task automatic do_read(input string tag, input logic [7:0] line, input int h, input int restart_at);
    int latch_first, latch_cnt, rises, width_bad, valid_first, valid_cnt, busy_bad, hold_bad, run;
    logic prev_clk;
    logic [7:0] exp_btn;
    exp_btn = ~line;
    pad_line = line;
    latch_first = -1; latch_cnt = 0; rises = 0; width_bad = 0;
    valid_first = -1; valid_cnt = 0; busy_bad = 0; hold_bad = 0; run = 0; prev_clk = 1'b0;
    @(negedge clk); start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0;
    for (int t = 0; t <= 18 * h + 6; t++) begin
      @(negedge clk);
      if (c_latch) begin
        latch_cnt++;
        if (latch_first < 0) latch_first = t;
      end
      if (c_clk != prev_clk) begin
        if (prev_clk && run != h) width_bad++;
        if (!prev_clk) begin
          rises++;
          if (rises > 1 && run != h) width_bad++;
        end
        run = 1;
      end else begin
        run++;
      end
      prev_clk = c_clk;
      if (c_valid) begin
        valid_cnt++;
        if (valid_first < 0) valid_first = t;
      end
      if (c_busy != (t >= 1 && t <= 18 * h + 1)) busy_bad++;
      if (t <= 18 * h && c_buttons != last_btn[sel]) hold_bad++;
      if (t == restart_at - 1) start_drv = 1'b1;
      if (t == restart_at) start_drv = 1'b0;
    end
    last_btn[sel] = exp_btn;
    chk({tag, " latch_start"}, latch_first, 1);
    chk({tag, " latch_width"}, latch_cnt, 2 * h);
    chk({tag, " clk_rises"}, rises, 7);
    chk({tag, " clk_width_errs"}, width_bad, 0);
    chk({tag, " valid_cycle"}, valid_first, 18 * h + 1);
    chk({tag, " valid_count"}, valid_cnt, 1);
    chk({tag, " busy_errs"}, busy_bad, 0);
    chk({tag, " buttons_hold_errs"}, hold_bad, 0);
    chk({tag, " buttons"}, int'(c_buttons), int'(exp_btn));
  endtask

  vec_t tbl [4];

  initial begin
    int vt;
    int bad;
    logic [7:0] rl;
    tbl[0] = '{line: 8'h5A, exp: 8'hA5};
    tbl[1] = '{line: 8'hFF, exp: 8'h00};
    tbl[2] = '{line: 8'h00, exp: 8'hFF};
    tbl[3] = '{line: 8'hE7, exp: 8'h18};
    last_btn[0] = 8'h00;
    last_btn[1] = 8'h00;

    // 1: reset held with random inputs
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start_drv = 1'($urandom);
      pad_line = 8'($urandom);
      if ({ifa.nes_latch, ifa.nes_clk, ifa.valid, ifa.busy} != 4'b0 || ifa.buttons != 8'h00) bad++;
      if ({ifb.nes_latch, ifb.nes_clk, ifb.valid, ifb.busy} != 4'b0 || ifb.buttons != 8'h00) bad++;
    end
    chk("reset outputs_nonzero", bad, 0);
    @(negedge clk); start_drv = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset busy", int'(ifa.busy), 0);
    chk("post_reset latch", int'(ifa.nes_latch), 0);

    // 2/3: table-driven reads on H=6
    for (int i = 0; i < 4; i++) begin
      do_read($sformatf("tbl%0d", i), tbl[i].line, 6, -1);
      chk($sformatf("tbl%0d table_exp", i), int'(ifa.buttons), int'(tbl[i].exp));
    end

    // randomized reads against the model (buttons = inverted line)
    for (int i = 0; i < 5; i++) begin
      rl = 8'($urandom);
      do_read($sformatf("rnd%0d", i), rl, 6, -1);
    end

    // 4: start pulsed mid-read is ignored
    do_read("restart30", 8'h96, 6, 30);

    // 4: start held high gives back-to-back reads
    pad_line = 8'h0F;
    @(negedge clk); start_drv = 1'b1;
    @(posedge clk);
    vt = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (c_valid) begin vt = t; break; end
    end
    chk("held valid_cycle", vt, 109);
    @(negedge clk);
    chk("held gap_latch", int'(c_latch), 0);
    chk("held gap_busy", int'(c_busy), 0);
    @(negedge clk);
    chk("held latch_rise", int'(c_latch), 1);
    start_drv = 1'b0;
    vt = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (c_valid) begin vt = t; break; end
    end
    chk("held second_valid_seen", int'(vt >= 0), 1);
    chk("held second_buttons", int'(c_buttons), 8'hF0);
    last_btn[0] = 8'hF0;
    repeat (3) @(negedge clk);

    // 5: reset mid-SHIFT
    do_read("pre_reset", 8'h5A, 6, -1);
    pad_line = 8'h00;
    @(negedge clk); start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0;
    for (int t = 0; t <= 50; t++) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset latch", int'(ifa.nes_latch), 0);
    chk("midreset clk", int'(ifa.nes_clk), 0);
    chk("midreset busy", int'(ifa.busy), 0);
    chk("midreset valid", int'(ifa.valid), 0);
    chk("midreset buttons", int'(ifa.buttons), 0);
    last_btn[0] = 8'h00;
    last_btn[1] = 8'h00;
    @(negedge clk); reset = 1'b1;
    bad = 0;
    for (int t = 0; t < 150; t++) begin
      @(negedge clk);
      if (ifa.valid || ifa.buttons != 8'h00 || ifa.busy) bad++;
    end
    chk("after_reset quiet_errs", bad, 0);
    do_read("fresh", 8'h3C, 6, -1);

    // 6: H=4 build
    sel = 1'b1;
    do_read("h4", 8'hC3, 4, -1);
    rl = 8'($urandom);
    do_read("h4rnd", rl, 4, -1);
    sel = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
